// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative divider.
package muldiv_pkg;

  localparam int XLEN = 32;

  // Quotient returned for any division by zero, signed or unsigned.
  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the divisor,
// keep the difference only when it did not borrow.
module div_iter_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  // One extra bit so a shifted remainder above 2^(XLEN-1) never overflows the trial subtract.
  logic [XLEN:0] w_diff;

  assign w_diff = {i_rem, i_quo[XLEN-1]} - {1'b0, i_divisor};
  assign o_rem  = w_diff[XLEN] ? {i_rem[XLEN-2:0], i_quo[XLEN-1]} : w_diff[XLEN-1:0];
  assign o_quo  = {i_quo[XLEN-2:0], ~w_diff[XLEN]};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU unit with request/result handshake and flush.
// Defining DIV_SEQ_CACHE_EN adds a one-entry cache of the last completed division.
module div_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            kill_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] res_data_o,
  output logic            stall_o
);
  import muldiv_pkg::*;

  div_state_e       r_state, w_nextState;
  div_op_e          w_op;
  logic             w_signed, w_accept, w_divZero, w_hit, w_fast;
  logic [XLEN-1:0]  w_absA, w_absB, w_fixQ, w_fixR, w_hitData, w_fastData;
  logic [XLEN-1:0]  w_remNext, w_quoNext;
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0]  r_rem, r_quo, r_divisor, r_result;
  logic             r_isRem, r_negQ, r_negR;

  assign w_op      = div_op_e'(req_op_i);
  assign w_signed  = (w_op == DIV) || (w_op == REM);
  assign w_accept  = req_valid_i && (r_state == IDLE) && !kill_i;
  assign w_divZero = (divisor_i == '0);
  assign w_absA    = (w_signed && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
  assign w_absB    = (w_signed && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;
  assign w_fixQ    = r_negQ ? -r_quo : r_quo;
  assign w_fixR    = r_negR ? -r_rem : r_rem;
  assign w_fast    = w_divZero || w_hit;
  assign w_fastData = w_divZero ? (req_op_i[1] ? dividend_i : XLEN'(DIV_ZERO_Q)) : w_hitData;
  assign res_data_o = r_result;

`ifdef DIV_SEQ_CACHE_EN
  logic            r_cValid, r_cSigned, r_keySigned;
  logic [XLEN-1:0] r_cA, r_cB, r_cQ, r_cR, r_keyA, r_keyB;

  // Op may differ from the cached one: both quotient and remainder are kept.
  assign w_hit     = r_cValid && (r_cSigned == w_signed) &&
                     (r_cA == dividend_i) && (r_cB == divisor_i);
  assign w_hitData = req_op_i[1] ? r_cR : r_cQ;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_cValid    <= 1'b0;
      r_cSigned   <= 1'b0;
      r_keySigned <= 1'b0;
      r_cA        <= '0;
      r_cB        <= '0;
      r_cQ        <= '0;
      r_cR        <= '0;
      r_keyA      <= '0;
      r_keyB      <= '0;
    end else if (w_accept) begin
      r_keyA      <= dividend_i;
      r_keyB      <= divisor_i;
      r_keySigned <= w_signed;
      if (w_divZero) begin
        r_cValid  <= 1'b1;
        r_cSigned <= w_signed;
        r_cA      <= dividend_i;
        r_cB      <= divisor_i;
        r_cQ      <= XLEN'(DIV_ZERO_Q);
        r_cR      <= dividend_i;
      end
    end else if (r_state == FIX && !kill_i) begin
      r_cValid  <= 1'b1;
      r_cSigned <= r_keySigned;
      r_cA      <= r_keyA;
      r_cB      <= r_keyB;
      r_cQ      <= w_fixQ;
      r_cR      <= w_fixR;
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_hitData = '0;
`endif

  div_iter_step #(.XLEN(XLEN)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_remNext),
    .o_quo     (w_quoNext)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_state <= IDLE;
    else           r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    req_ready_o = 1'b0;
    res_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (w_accept) w_nextState = w_fast ? DONE : CALC;
      end
      CALC: if (r_count == '0) w_nextState = FIX;
      FIX:  w_nextState = DONE;
      DONE: begin
        res_valid_o = !kill_i;
        if (res_ready_i) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
    // A flush wins over every transition, including the result handshake.
    if (kill_i) w_nextState = IDLE;
    stall_o = (r_state != IDLE) && !(res_valid_o && res_ready_i);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_count   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_result  <= '0;
      r_isRem   <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
    end else if (w_accept) begin
      r_count   <= CNT_W'(XLEN - 1);
      r_rem     <= '0;
      r_quo     <= w_absA;
      r_divisor <= w_absB;
      r_isRem   <= req_op_i[1];
      r_negQ    <= w_signed && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
      r_negR    <= w_signed && dividend_i[XLEN-1];
      if (w_fast) r_result <= w_fastData;
    end else if (r_state == CALC) begin
      r_rem   <= w_remNext;
      r_quo   <= w_quoNext;
      r_count <= r_count - 1'b1;
    end else if (r_state == FIX) begin
      r_result <= r_isRem ? w_fixR : w_fixQ;
    end
  end

endmodule
